// File: rtl/way_allocator.sv
// Per-set way allocator: picks the lowest empty way of a set, or a
// round-robin victim when the set is full. It also supports per-way
// invalidation and a whole-array flush that clears one set per cycle.
module way_allocator #(
    parameter int NUM_WAYS   = 8,
    parameter int INDEX_BITS = 4,
    parameter int WAY_BITS   = $clog2(NUM_WAYS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [INDEX_BITS-1:0] req_index,
    output logic                  req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [NUM_WAYS-1:0]   resp_way,
    output logic                  resp_evict,
    output logic [WAY_BITS:0]     resp_count,
    input  logic                  inv_valid,
    input  logic [INDEX_BITS-1:0] inv_index,
    input  logic [NUM_WAYS-1:0]   inv_mask,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  flush_done
);
    localparam int NUM_SETS = 2**INDEX_BITS;

    typedef enum logic [1:0] {IDLE, RESP, FLUSH} state_t;
    state_t state;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0][WAY_BITS-1:0] rr_q, rr_d;
    logic [INDEX_BITS-1:0]             flush_cnt;

    logic                accept;
    logic [NUM_WAYS-1:0] sel_valid, free_way, rr_way, alloc_way, new_sel;
    logic                sel_full;
    logic [WAY_BITS:0]   new_count;

    assign req_ready = (state == IDLE) && !flush_req;
    assign accept    = req_ready && req_valid;

    // Victim/empty-way selection from the pre-update state of the addressed set
    always_comb begin
        sel_valid = valid_q[req_index];
        sel_full  = &sel_valid;
        free_way  = '0;
        for (int i = NUM_WAYS-1; i >= 0; i--) begin
            if (!sel_valid[i]) begin
                free_way    = '0;
                free_way[i] = 1'b1;
            end
        end
        rr_way = '0;
        rr_way[rr_q[req_index]] = 1'b1;
        alloc_way = sel_full ? rr_way : free_way;
        // A same-set invalidate lands first, so the allocation wins on overlap
        new_sel = sel_valid;
        if (inv_valid && state != FLUSH && inv_index == req_index)
            new_sel = new_sel & ~inv_mask;
        new_sel = new_sel | alloc_way;
        new_count = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            new_count = new_count + (WAY_BITS+1)'(new_sel[i]);
    end

    // Next-state occupancy and pointers: flush clear, invalidate, then allocate
    always_comb begin
        valid_d = valid_q;
        rr_d    = rr_q;
        for (int s = 0; s < NUM_SETS; s++) begin
            if (state == FLUSH) begin
                if (flush_cnt == INDEX_BITS'(s)) begin
                    valid_d[s] = '0;
                    rr_d[s]    = '0;
                end
            end else begin
                if (inv_valid && inv_index == INDEX_BITS'(s))
                    valid_d[s] = valid_d[s] & ~inv_mask;
                if (accept && req_index == INDEX_BITS'(s)) begin
                    valid_d[s] = valid_d[s] | alloc_way;
                    if (sel_full)
                        rr_d[s] = rr_q[s] + 1'b1;
                end
            end
        end
    end

    // Control FSM with registered response/flush outputs and set-state storage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            valid_q    <= '0;
            rr_q       <= '0;
            flush_cnt  <= '0;
            resp_valid <= 1'b0;
            resp_way   <= '0;
            resp_evict <= 1'b0;
            resp_count <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rr_q       <= rr_d;
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state      <= FLUSH;
                        flush_cnt  <= '0;
                        flush_busy <= 1'b1;
                    end else if (req_valid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_way   <= alloc_way;
                        resp_evict <= sel_full;
                        resp_count <= new_count;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == INDEX_BITS'(NUM_SETS-1)) begin
                        state      <= IDLE;
                        flush_busy <= 1'b0;
                        flush_done <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_way_allocator.sv
// Scoreboard bench for way_allocator (8 ways, 4 sets): the driver queues
// expected responses and a monitor checks each response at its handshake.
module tb_way_allocator;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_index = '0;
    logic       req_ready;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_way;
    logic       resp_evict;
    logic [3:0] resp_count;
    logic       inv_valid = 1'b0;
    logic [1:0] inv_index = '0;
    logic [7:0] inv_mask = '0;
    logic       flush_req = 1'b0;
    logic       flush_busy;
    logic       flush_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [12:0] exp_q[$];

    way_allocator #(.NUM_WAYS(8), .INDEX_BITS(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_way(resp_way), .resp_evict(resp_evict), .resp_count(resp_count),
        .inv_valid(inv_valid), .inv_index(inv_index), .inv_mask(inv_mask),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each response on the cycle its handshake completes
    always @(negedge clock) begin
        if (reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: way 0x%0h with empty scoreboard", resp_way);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                chk("resp_way",   {24'd0, resp_way},   {24'd0, e[12:5]});
                chk("resp_evict", {31'd0, resp_evict}, {31'd0, e[4]});
                chk("resp_count", {28'd0, resp_count}, {28'd0, e[3:0]});
            end
        end
    end

    // Issue one allocation (optionally with a same-set invalidate) and wait it out
    task automatic alloc(input logic [1:0] idx, input logic [7:0] w, input logic e,
                         input logic [3:0] c, input logic [7:0] im = 8'h00);
        int t;
        t = 0;
        while (!req_ready && t < 20) begin @(posedge clock); #1; t++; end
        if (t == 20) begin
            n_checks++; n_fail++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_valid = 1'b1; req_index = idx;
        inv_valid = (im != 8'h00); inv_index = idx; inv_mask = im;
        exp_q.push_back({w, e, c});
        @(posedge clock); #1;
        req_valid = 1'b0; inv_valid = 1'b0;
        t = 0;
        while (resp_valid && t < 20) begin @(posedge clock); #1; t++; end
        if (t == 20) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: resp_valid stuck at 1 expected 0");
        end
    endtask

    task automatic inv(input logic [1:0] idx, input logic [7:0] m);
        inv_valid = 1'b1; inv_index = idx; inv_mask = m;
        @(posedge clock); #1;
        inv_valid = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_cnt;
        // Reset state
        #12;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
        chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
        chk("rst_resp_way",   {24'd0, resp_way},   32'd0);
        chk("rst_resp_count", {28'd0, resp_count}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // 1: fill set 1, then two round-robin victims
        for (int i = 0; i < 8; i++)
            alloc(2'd1, 8'(1 << i), 1'b0, 4'(i + 1));
        alloc(2'd1, 8'h01, 1'b1, 4'd8);
        alloc(2'd1, 8'h02, 1'b1, 4'd8);

        // 2: a hole from invalidate is refilled before any victim is taken
        inv(2'd1, 8'h10);
        alloc(2'd1, 8'h10, 1'b0, 4'd8);
        alloc(2'd1, 8'h04, 1'b1, 4'd8);

        // 3: backpressure holds the response and blocks new requests
        chk("bp_ready_before", {31'd0, req_ready}, 32'd1);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_index = 2'd0;
        exp_q.push_back({8'h01, 1'b0, 4'd1});
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_req_ready",  {31'd0, req_ready},  32'd0);
            chk("bp_resp_way",   {24'd0, resp_way},   32'h01);
            chk("bp_resp_count", {28'd0, resp_count}, 32'd1);
            @(posedge clock); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_resp_done",  {31'd0, resp_valid}, 32'd0);
        chk("bp_ready_after", {31'd0, req_ready}, 32'd1);
        alloc(2'd0, 8'h02, 1'b0, 4'd2);

        // 4: fill set 2, then allocate and invalidate set 2 on the same edge
        for (int i = 0; i < 8; i++)
            alloc(2'd2, 8'(1 << i), 1'b0, 4'(i + 1));
        alloc(2'd2, 8'h01, 1'b1, 4'd7, 8'h04);
        alloc(2'd2, 8'h04, 1'b0, 4'd8);

        // 5: flush with partially filled sets; invalidate during flush is ignored
        alloc(2'd3, 8'h01, 1'b0, 4'd1);
        flush_req = 1'b1;
        @(posedge clock); #1;
        flush_req = 1'b0;
        inv_valid = 1'b1; inv_index = 2'd3; inv_mask = 8'hff;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (flush_busy) begin
                busy_cnt++;
                chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
            end
            if (flush_done) done_cnt++;
            @(posedge clock); #1;
            inv_valid = 1'b0;
        end
        chk("flush_busy_cycles", busy_cnt, 32'd4);
        chk("flush_done_cycles", done_cnt, 32'd1);
        alloc(2'd3, 8'h01, 1'b0, 4'd1);
        alloc(2'd1, 8'h01, 1'b0, 4'd1);
        alloc(2'd2, 8'h01, 1'b0, 4'd1);

        // 6a: asynchronous reset in the middle of a held response
        resp_ready = 1'b0;
        req_valid = 1'b1; req_index = 2'd0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("mid_resp_valid", {31'd0, resp_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_resp_way",   {24'd0, resp_way},   32'd0);
        #3 reset = 1'b1;
        resp_ready = 1'b1;
        @(posedge clock); #1;

        // 6b: asynchronous reset in the middle of a flush
        flush_req = 1'b1;
        @(posedge clock); #1;
        flush_req = 1'b0;
        @(posedge clock); #1;
        chk("mid_flush_busy", {31'd0, flush_busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_flush_busy", {31'd0, flush_busy}, 32'd0);
        chk("arst_flush_done", {31'd0, flush_done}, 32'd0);
        chk("arst_req_ready",  {31'd0, req_ready},  32'd1);
        #3 reset = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("post_rst_no_done", {31'd0, flush_done}, 32'd0);
        end
        @(posedge clock); #1;
        alloc(2'd0, 8'h01, 1'b0, 4'd1);

        repeat (3) @(posedge clock);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
